// File: rtl/rv_fetch.sv
// rv_fetch: instruction fetch stage. It issues one instruction-memory read at a time
// and hands the registered word to decode under a valid/ready handshake.
module rv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [6:0]  instr_op_o,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        fetch_err_o,
    output logic [1:0]  err_cause_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, VALID, ERR} state_t;

    state_t      state_q;
    logic [31:0] pc_q, pc_d, instr_q, ipc_q;
    logic [1:0]  cause_q;

    assign pc_d = branch_taken_i ? branch_target_i : pc_q + 32'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0013;
            ipc_q   <= 32'h0;
            cause_q <= 2'd0;
        end else begin
            case (state_q)
                IDLE:  state_q <= REQ;
                REQ:   if (imem_gnt_i) state_q <= WAIT;
                WAIT:  if (imem_rvalid_i) begin
                    if (imem_err_i) begin
                        state_q <= ERR;
                        cause_q <= 2'd2;
                    end else begin
                        instr_q <= imem_rdata_i;
                        ipc_q   <= pc_q;
                        state_q <= VALID;
                    end
                end
                VALID: if (instr_ready_i) begin
                    // a misaligned target halts fetch before it can reach the address bus
                    if (pc_d[1:0] != 2'b00) begin
                        state_q <= ERR;
                        cause_q <= 2'd1;
                    end else begin
                        pc_q    <= pc_d;
                        state_q <= REQ;
                    end
                end
                ERR:   state_q <= ERR;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req_o    = state_q == REQ;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = state_q == VALID;
    assign instr_o       = instr_q;
    assign instr_pc_o    = ipc_q;
    assign instr_op_o    = instr_q[6:0];
    assign fetch_err_o   = state_q == ERR;
    assign err_cause_o   = cause_q;
endmodule

// File: tb/tb_rv_fetch.sv
// tb_rv_fetch: directed vector table for rv_fetch with RESET_PC=0x1000,
// plus a hand-written reset-during-WAIT sequence.
module tb_rv_fetch;
    localparam logic [31:0] R = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, gnt, rv, rerr, rdy, bt;
    logic [31:0] rdata, btgt;
    logic        req, valid, ferr;
    logic [31:0] addr, instr, ipc;
    logic [6:0]  op;
    logic [1:0]  cause;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    rv_fetch #(.RESET_PC(R)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rv), .imem_rdata_i(rdata), .imem_err_i(rerr),
        .instr_valid_o(valid), .instr_ready_i(rdy), .instr_o(instr),
        .instr_pc_o(ipc), .instr_op_o(op),
        .branch_taken_i(bt), .branch_target_i(btgt),
        .fetch_err_o(ferr), .err_cause_o(cause)
    );

    typedef struct {
        logic        rst, gnt, rv, rerr, rdy, bt;
        logic [31:0] rdata, btgt;
        logic        e_req, e_valid, e_err, chk;
        logic [31:0] e_addr, e_instr, e_ipc;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic g, logic v, logic e, logic [31:0] d,
                                logic y, logic b, logic [31:0] t,
                                logic eq, logic [31:0] ea, logic ev, logic ee,
                                logic [1:0] ec, logic c, logic [31:0] ei, logic [31:0] ep);
        vec_t x;
        x.rst = r; x.gnt = g; x.rv = v; x.rerr = e; x.rdata = d; x.rdy = y; x.bt = b; x.btgt = t;
        x.e_req = eq; x.e_addr = ea; x.e_valid = ev; x.e_err = ee; x.e_cause = ec;
        x.chk = c; x.e_instr = ei; x.e_ipc = ep;
        return x;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(logic r, logic g, logic v, logic e, logic [31:0] d,
                         logic y, logic b, logic [31:0] t);
        rst = r; gnt = g; rv = v; rerr = e; rdata = d; rdy = y; bt = b; btgt = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // IDLE -> REQ, then the main fetch/consume/backpressure/redirect flow
        vecs.push_back(mk(1,0,0,0,0,0,0,0,           0,R,0,0,0,1,32'h13,0));
        vecs.push_back(mk(1,0,0,0,0,0,0,0,           0,R,0,0,0,1,32'h13,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,R,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,           0,R,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,32'h00500093,0,0,0, 0,R,1,0,0,1,32'h00500093,R));
        vecs.push_back(mk(0,0,1,0,32'hdeadbeef,0,1,2,  0,R,1,0,0,1,32'h00500093,R));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,R,1,0,0,1,32'h00500093,R));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,R,1,0,0,1,32'h00500093,R));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,R,1,0,0,1,32'h00500093,R));
        vecs.push_back(mk(0,0,0,0,0,1,0,0,           1,R+4,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,2,           1,R+4,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,2,           1,R+4,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,1,2,           1,R+4,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,           0,R+4,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,           0,R+4,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,32'h00000063,0,0,0, 0,R+4,1,0,0,1,32'h00000063,R+4));
        vecs.push_back(mk(0,0,0,0,0,1,1,32'h2000,    1,32'h2000,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,           0,32'h2000,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,32'h0000006f,0,0,0, 0,32'h2000,1,0,0,1,32'h0000006f,32'h2000));
        // misaligned redirect: sticky error, pc kept, no requests
        vecs.push_back(mk(0,0,0,0,0,1,1,32'h2002,    0,32'h2000,0,1,1,0,0,0));
        vecs.push_back(mk(0,1,1,0,32'h13,1,0,0,      0,32'h2000,0,1,1,0,0,0));
        vecs.push_back(mk(0,1,1,0,32'h13,1,0,0,      0,32'h2000,0,1,1,0,0,0));
        // bus error response
        vecs.push_back(mk(1,0,0,0,0,0,0,0,           0,R,0,0,0,1,32'h13,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,R,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,           0,R,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,1,32'h00500093,0,0,0, 0,R,0,1,2,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,1,1,32'h3000,    0,R,0,1,2,0,0,0));
        // wrap from 0xFFFF_FFFC to 0
        vecs.push_back(mk(1,0,0,0,0,0,0,0,           0,R,0,0,0,1,32'h13,0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,           1,R,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,           0,R,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,32'h00000013,0,0,0, 0,R,1,0,0,1,32'h00000013,R));
        vecs.push_back(mk(0,0,0,0,0,1,1,32'hfffffffc, 1,32'hfffffffc,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,           0,32'hfffffffc,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,32'h00100073,0,0,0, 0,32'hfffffffc,1,0,0,1,32'h00100073,32'hfffffffc));
        vecs.push_back(mk(0,0,0,0,0,1,0,0,           1,32'h0,0,0,0,0,0,0));
        vecs.push_back(mk(0,1,0,0,0,0,0,0,           0,32'h0,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,1,0,32'h00000033,0,0,0, 0,32'h0,1,0,0,1,32'h00000033,32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].gnt, vecs[i].rv, vecs[i].rerr, vecs[i].rdata,
                  vecs[i].rdy, vecs[i].bt, vecs[i].btgt);
            check($sformatf("v%0d_req", i), {31'b0, req}, {31'b0, vecs[i].e_req});
            check($sformatf("v%0d_addr", i), addr, vecs[i].e_addr);
            check($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d_err", i), {31'b0, ferr}, {31'b0, vecs[i].e_err});
            check($sformatf("v%0d_cause", i), {30'b0, cause}, {30'b0, vecs[i].e_cause});
            if (vecs[i].chk) begin
                check($sformatf("v%0d_instr", i), instr, vecs[i].e_instr);
                check($sformatf("v%0d_ipc", i), ipc, vecs[i].e_ipc);
                check($sformatf("v%0d_op", i), {25'b0, op}, {25'b0, vecs[i].e_instr[6:0]});
            end
        end

        // reset asserted while a read is outstanding; the late response must be dropped
        drive(1,0,0,0,0,0,0,0);
        drive(0,0,0,0,0,0,0,0);
        drive(0,1,0,0,0,0,0,0);
        check("rw_wait_req", {31'b0, req}, 32'd0);
        drive(1,0,0,0,0,0,0,0);
        check("rw_rst_req", {31'b0, req}, 32'd0);
        check("rw_rst_addr", addr, R);
        check("rw_rst_valid", {31'b0, valid}, 32'd0);
        check("rw_rst_instr", instr, 32'h13);
        check("rw_rst_ipc", ipc, 32'h0);
        check("rw_rst_err", {31'b0, ferr}, 32'd0);
        drive(0,0,1,0,32'hffffffff,0,0,0);
        check("rw_late_valid", {31'b0, valid}, 32'd0);
        check("rw_first_req", {31'b0, req}, 32'd1);
        check("rw_first_addr", addr, R);
        drive(0,0,1,0,32'hffffffff,0,0,0);
        check("rw_late_valid2", {31'b0, valid}, 32'd0);
        check("rw_hold_req", {31'b0, req}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
